mem_io_ctrl: RTL and testbench

- Memory/I-O access controller directly downstream of the CPU's memory port in the Simple RISC Machine.
- Accepts one CPU access at a time over a req/ack handshake and decodes the 9-bit address to one of: synchronous data RAM, LED register, switch input, or free-running cycle counter.
- Returns read data with a one-cycle ack pulse; RAM and I/O latency is fixed and deterministic, so the CPU FSM waits on ack instead of counting cycles.

---
 rtl/mem_io_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_io_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_ctrl.sv
// Memory/I-O access controller: one CPU access at a time over req/ack, decoded to
// synchronous RAM, LED register, synchronized switches or a free-running cycle counter.
module mem_io_ctrl #(
    parameter int unsigned       ADDR_W   = 9,
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       RAM_AW   = 8,
    parameter int unsigned       RD_WAIT  = 1,
    parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140,
    parameter logic [ADDR_W-1:0] CNT_ADDR = 9'h180
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [7:0]        sw_in,
    input  logic              halt_in,
    output logic [7:0]        led_out,
    output logic              err_flag
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned WAIT_W   = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam bit          HAS_WAIT = (RD_WAIT != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_ACK
    } state_t;

    state_t              state;
    logic                req_write;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]    cnt;
    logic [7:0]          sw_meta;
    logic [7:0]          sw_sync;

    logic is_ram;
    logic is_led;
    logic is_sw;
    logic is_cnt;
    logic is_unmapped;

    // Decode always works on the latched address, never the live CPU bus.
    assign is_ram      = ~req_addr[ADDR_W-1];
    assign is_led      = (req_addr == LED_ADDR);
    assign is_sw       = (req_addr == SW_ADDR);
    assign is_cnt      = (req_addr == CNT_ADDR);
    assign is_unmapped = ~(is_ram | is_led | is_sw | is_cnt);

    assign ram_addr  = req_addr[RAM_AW-1:0];
    assign ram_wdata = req_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            wait_cnt  <= '0;
            cnt       <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            ram_we    <= 1'b0;
            led_out   <= '0;
            err_flag  <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ram_we  <= 1'b0;
            sw_meta <= sw_in;
            sw_sync <= sw_meta;

            // A counter write clears it and wins over the free-running increment.
            if (state == S_ACCESS && req_write && is_cnt) begin
                cnt <= '0;
            end else if (!halt_in) begin
                cnt <= cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        req_write <= cpu_write;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        ram_we    <= cpu_write & ~cpu_addr[ADDR_W-1];
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (HAS_WAIT && is_ram && !req_write) begin
                        wait_cnt <= WAIT_W'(RD_WAIT - 1);
                        state    <= S_WAIT;
                    end else begin
                        if (is_ram && !req_write) begin
                            cpu_rdata <= ram_rdata;
                        end
                        if (is_led && req_write) begin
                            led_out <= req_wdata[7:0];
                        end
                        if (is_sw && !req_write) begin
                            cpu_rdata <= DATA_W'(sw_sync);
                        end
                        if (is_cnt && !req_write) begin
                            cpu_rdata <= DATA_W'(cnt);
                        end
                        if (is_unmapped) begin
                            err_flag <= 1'b1;
                            if (!req_write) begin
                                cpu_rdata <= '0;
                            end
                        end
                        cpu_ack <= 1'b1;
                        state   <= S_ACK;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        cpu_rdata <= ram_rdata;
                        cpu_ack   <= 1'b1;
                        state     <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Scoreboard bench for mem_io_ctrl: a driver issues directed and random accesses and
// pushes expected read data / ack cycle; a monitor pops and compares on every ack.
module tb_mem_io_ctrl;

    localparam int unsigned RD_WAIT  = 1;
    localparam logic [8:0]  LED_ADDR = 9'h100;
    localparam logic [8:0]  SW_ADDR  = 9'h140;
    localparam logic [8:0]  CNT_ADDR = 9'h180;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req;
    logic        cpu_write;
    logic [8:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [7:0]  sw_in;
    logic        halt_in;
    logic [7:0]  led_out;
    logic        err_flag;

    always #5 clk = ~clk;

    mem_io_ctrl #(
        .ADDR_W  (9),
        .DATA_W  (16),
        .RAM_AW  (8),
        .RD_WAIT (RD_WAIT),
        .LED_ADDR(LED_ADDR),
        .SW_ADDR (SW_ADDR),
        .CNT_ADDR(CNT_ADDR)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu_req  (cpu_req),
        .cpu_write(cpu_write),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .sw_in    (sw_in),
        .halt_in  (halt_in),
        .led_out  (led_out),
        .err_flag (err_flag)
    );

    // External synchronous RAM seen by the DUT
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Edge counters: total edges, and edges at which the cycle counter may advance
    int cyc     = 0;
    int run_cnt = 0;
    int we_cnt  = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!halt_in) run_cnt <= run_cnt + 1;
    end
    always @(negedge clk) if (ram_we === 1'b1) we_cnt <= we_cnt + 1;

    typedef struct {
        logic [15:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [15:0] ref_mem [256];
    logic [7:0]  led_exp;
    bit          err_exp;
    logic [15:0] last_rd;
    int          run_base;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (cpu_ack === 1'b1) begin
            chk("ack_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", 32'(cpu_rdata), 32'(e.rdata));
                chk("ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic access(input bit w, input logic [8:0] a, input logic [15:0] d,
                          input bit b2b, input bit keep);
        exp_t        e;
        int          we0;
        bit          got;
        bit          clr;
        logic [15:0] rv;
        clr = 1'b0;
        got = 1'b0;
        if (!b2b) @(negedge clk);
        cpu_req   = 1'b1;
        cpu_write = w;
        cpu_addr  = a;
        cpu_wdata = d;
        we0       = we_cnt;
        if (b2b) @(posedge clk);
        @(posedge clk);
        #1;
        e.cyc = cyc + 1 + ((!a[8] && !w) ? int'(RD_WAIT) : 0);
        if (!w) begin
            if (!a[8])              rv = ref_mem[a[7:0]];
            else if (a == SW_ADDR)  rv = {8'h00, sw_in};
            else if (a == CNT_ADDR) rv = 16'(run_cnt - run_base);
            else begin
                rv      = 16'h0000;
                err_exp = 1'b1;
            end
            last_rd = rv;
        end else begin
            if (!a[8])              ref_mem[a[7:0]] = d;
            else if (a == LED_ADDR) led_exp = d[7:0];
            else if (a == CNT_ADDR) clr = 1'b1;
            else if (a != SW_ADDR)  err_exp = 1'b1;
        end
        e.rdata = last_rd;
        sb.push_back(e);
        if (clr) begin
            @(posedge clk);
            #1;
            run_base = run_cnt;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
        if (!keep) cpu_req = 1'b0;
        chk("ram_we_cycles", 32'(we_cnt - we0), (w && !a[8]) ? 32'd1 : 32'd0);
        chk("led_out", 32'(led_out), 32'(led_exp));
        chk("err_flag", 32'(err_flag), 32'(err_exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r1;
        logic [8:0]  a;
        int          kind;
        foreach (mem[i]) mem[i] = 16'h0000;
        foreach (ref_mem[i]) ref_mem[i] = 16'h0000;
        led_exp   = 8'h00;
        err_exp   = 1'b0;
        last_rd   = 16'h0000;
        reset_n   = 1'b0;
        cpu_req   = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        sw_in     = 8'h00;
        halt_in   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_led", 32'(led_out), 32'd0);
        chk("rst_err", 32'(err_flag), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        reset_n  = 1'b1;
        run_base = run_cnt;

        // Dirty LED / err / rdata, then reset in the middle of a RAM read
        access(1'b1, 9'h100, 16'h005A, 1'b0, 1'b0);
        access(1'b0, 9'h1FF, 16'h0000, 1'b0, 1'b0);
        access(1'b1, 9'h019, 16'h1234, 1'b0, 1'b0);
        access(1'b0, 9'h019, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_write = 1'b0;
        cpu_addr  = 9'h019;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("midrst_ram_we", 32'(ram_we), 32'd0);
        chk("midrst_led", 32'(led_out), 32'd0);
        chk("midrst_err", 32'(err_flag), 32'd0);
        chk("midrst_rdata", 32'(cpu_rdata), 32'd0);
        repeat (4) @(negedge clk);
        reset_n  = 1'b1;
        run_base = run_cnt;
        led_exp  = 8'h00;
        err_exp  = 1'b0;
        last_rd  = 16'h0000;

        // RAM write then read back
        access(1'b1, 9'h019, 16'hFFE9, 1'b0, 1'b0);
        access(1'b0, 9'h019, 16'h0000, 1'b0, 1'b0);
        // LED and switches
        access(1'b1, LED_ADDR, 16'h12A5, 1'b0, 1'b0);
        @(negedge clk);
        sw_in = 8'h3C;
        repeat (2) @(negedge clk);
        access(1'b0, SW_ADDR, 16'h0000, 1'b0, 1'b0);
        access(1'b1, SW_ADDR, 16'hBEEF, 1'b0, 1'b0);
        // Counter frozen while halted
        @(negedge clk);
        halt_in = 1'b1;
        access(1'b0, CNT_ADDR, 16'h0000, 1'b0, 1'b0);
        r1 = cpu_rdata;
        repeat (10) @(negedge clk);
        access(1'b0, CNT_ADDR, 16'h0000, 1'b0, 1'b0);
        chk("cnt_halt_hold", 32'(cpu_rdata), 32'(r1));
        // Clear then read a few cycles later
        halt_in = 1'b0;
        access(1'b1, CNT_ADDR, 16'h0000, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        access(1'b0, CNT_ADDR, 16'h0000, 1'b0, 1'b0);
        // Unmapped accesses are sticky and side-effect free
        access(1'b0, 9'h1FF, 16'h0000, 1'b0, 1'b0);
        access(1'b1, 9'h1C0, 16'h7777, 1'b0, 1'b0);
        access(1'b0, 9'h019, 16'h0000, 1'b0, 1'b0);
        // Back-to-back with req held through ack
        access(1'b1, 9'h020, 16'hA55A, 1'b0, 1'b1);
        access(1'b0, 9'h020, 16'h0000, 1'b1, 1'b0);

        // Randomized mix
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) halt_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) sw_in = 8'($urandom);
            repeat (2) @(negedge clk);
            kind = int'($urandom_range(0, 9));
            if (kind <= 4) begin
                access(1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)),
                       16'($urandom), 1'b0, 1'b0);
            end else if (kind == 5) begin
                access(1'b1, LED_ADDR, 16'($urandom), 1'b0, 1'b0);
            end else if (kind == 6) begin
                access(1'($urandom_range(0, 1)), SW_ADDR, 16'($urandom), 1'b0, 1'b0);
            end else if (kind == 7) begin
                access(1'($urandom_range(0, 3) == 0), CNT_ADDR, 16'($urandom), 1'b0, 1'b0);
            end else if (kind == 8) begin
                a = {1'b1, 8'($urandom)};
                if (a == LED_ADDR || a == SW_ADDR || a == CNT_ADDR) a = 9'h1FF;
                access(1'($urandom_range(0, 1)), a, 16'($urandom), 1'b0, 1'b0);
            end else begin
                access(1'b1, 9'($urandom_range(0, 15)), 16'($urandom), 1'b0, 1'b1);
                access(1'b0, 9'($urandom_range(0, 15)), 16'h0000, 1'b1, 1'b0);
            end
        end

        // Counter wrap past 16'hFFFF
        @(negedge clk);
        halt_in = 1'b0;
        access(1'b1, CNT_ADDR, 16'h0000, 1'b0, 1'b0);
        repeat (65540) @(negedge clk);
        access(1'b0, CNT_ADDR, 16'h0000, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
